// File: rtl/mmio_io_bridge_if.sv
// ============================================================================
// Module      : mmio_io_bridge_if
// Description : Data-memory-side bus between the MIPS core and the I/O bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_io_bridge_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Hit;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  Hit, ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output Hit, ReadData
  );
endinterface

`default_nettype wire

// File: rtl/mmio_io_bridge.sv
// ============================================================================
// Module      : mmio_io_bridge
// Description : 16-byte MMIO window with output port, synchronised input port
//               with change flag, and an 8N1 serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_io_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter int          CLKS_PER_BIT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mmio_io_bridge_if.slave  bus,
  input  wire logic [7:0]  PortIn,
  output logic      [31:0] PortOut,
  output logic             TxSerial,
  output logic             TxBusy
);

  localparam int                c_cntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_selOut    = 2'd0;
  localparam logic [1:0] c_selIn     = 2'd1;
  localparam logic [1:0] c_selStatus = 2'd2;
  localparam logic [1:0] c_selTxData = 2'd3;

  localparam logic [1:0] c_stIdle  = 2'd0;
  localparam logic [1:0] c_stStart = 2'd1;
  localparam logic [1:0] c_stData  = 2'd2;
  localparam logic [1:0] c_stStop  = 2'd3;

  logic              w_hit;
  logic              w_wrEn;
  logic [1:0]        w_sel;
  logic [31:0]       w_readMux;
  logic              w_txWrite;
  logic              w_unusedAddrBits;

  logic [31:0]       r_portOut;
  logic [7:0]        r_s1;
  logic [7:0]        r_inSync;
  logic [7:0]        r_prev;
  logic              r_changed;

  logic [1:0]        r_txState;
  logic [7:0]        r_shift;
  logic [c_cntW-1:0] r_cnt;
  logic [2:0]        r_bitIdx;
  logic              r_txSerial;
  logic              r_txBusy;

  assign w_hit            = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign w_sel            = bus.Address[3:2];
  assign w_wrEn           = bus.MemWrite & w_hit;
  assign w_unusedAddrBits = ^bus.Address[1:0];
  // Busy is sampled as registered, so a write on the frame's final edge is dropped.
  assign w_txWrite        = w_wrEn && (w_sel == c_selTxData) && !r_txBusy;

  always_comb begin
    w_readMux = 32'h0;
    case (w_sel)
      c_selOut:    w_readMux = r_portOut;
      c_selIn:     w_readMux = {24'h0, r_inSync};
      c_selStatus: w_readMux = {30'h0, r_txBusy, r_changed};
      default:     w_readMux = 32'h0;
    endcase
  end

  assign bus.Hit      = w_hit;
  assign bus.ReadData = (bus.MemRead && w_hit) ? w_readMux : 32'h0;
  assign PortOut      = r_portOut;
  assign TxSerial     = r_txSerial;
  assign TxBusy       = r_txBusy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_portOut <= 32'h0;
    end else if (w_wrEn && (w_sel == c_selOut)) begin
      r_portOut <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1      <= 8'h0;
      r_inSync  <= 8'h0;
      r_prev    <= 8'h0;
      r_changed <= 1'b0;
    end else begin
      r_s1     <= PortIn;
      r_inSync <= r_s1;
      r_prev   <= r_inSync;
      // A fresh change takes priority over a simultaneous write-1-to-clear.
      if (r_inSync != r_prev) begin
        r_changed <= 1'b1;
      end else if (w_wrEn && (w_sel == c_selStatus) && bus.WriteData[0]) begin
        r_changed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txState  <= c_stIdle;
      r_shift    <= 8'h0;
      r_cnt      <= '0;
      r_bitIdx   <= 3'd0;
      r_txSerial <= 1'b1;
      r_txBusy   <= 1'b0;
    end else begin
      case (r_txState)
        c_stIdle: begin
          if (w_txWrite) begin
            r_shift    <= bus.WriteData[7:0];
            r_cnt      <= '0;
            r_bitIdx   <= 3'd0;
            r_txState  <= c_stStart;
            r_txSerial <= 1'b0;
            r_txBusy   <= 1'b1;
          end
        end
        c_stStart: begin
          if (r_cnt == c_cntLast) begin
            r_cnt      <= '0;
            r_txState  <= c_stData;
            r_txSerial <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + c_cntW'(1);
          end
        end
        c_stData: begin
          if (r_cnt == c_cntLast) begin
            r_cnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_txState  <= c_stStop;
              r_txSerial <= 1'b1;
            end else begin
              r_shift    <= {1'b0, r_shift[7:1]};
              r_bitIdx   <= r_bitIdx + 3'd1;
              r_txSerial <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + c_cntW'(1);
          end
        end
        c_stStop: begin
          if (r_cnt == c_cntLast) begin
            r_cnt     <= '0;
            r_txState <= c_stIdle;
            r_txBusy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cntW'(1);
          end
        end
        default: begin
          r_txState  <= c_stIdle;
          r_txSerial <= 1'b1;
          r_txBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_bridge.sv
// ============================================================================
// Module      : tb_mmio_io_bridge
// Description : Directed bench for mmio_io_bridge with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_bridge;

  localparam logic [31:0] BASE = 32'hFFFF0000;
  localparam int          CPB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  portIn = 8'h0;
  logic [31:0] portOut;
  logic        txSerial;
  logic        txBusy;

  int nVec = 0;
  int nMis = 0;

  mmio_io_bridge_if bus();

  mmio_io_bridge #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(portIn),
    .PortOut(portOut), .TxSerial(txSerial), .TxBusy(txBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin history per edge since reset, and a frame described by start edge + byte.
  int          mEdges;
  logic [7:0]  pinLog[$];
  logic [31:0] mPortOut;
  logic        mChanged;
  bit          mActive;
  int          mStart;
  logic [7:0]  mByte;

  function automatic logic [7:0] pinAt(input int k);
    if (k < 0 || k >= pinLog.size()) return 8'h0;
    return pinLog[k];
  endfunction

  function automatic bit busyAt(input int n);
    return mActive && ((n - mStart) < 10 * CPB);
  endfunction

  function automatic logic serialAt(input int n);
    int b;
    if (!busyAt(n)) return 1'b1;
    b = (n - mStart) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return mByte[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mEdges   = 0;
      pinLog.delete();
      mPortOut = 32'h0;
      mChanged = 1'b0;
      mActive  = 1'b0;
      mStart   = 0;
      mByte    = 8'h0;
    end else begin
      bit wrHit;
      int n;
      wrHit = bus.MemWrite && (bus.Address[31:4] == BASE[31:4]);
      n = mEdges + 1;
      pinLog.push_back(portIn);
      if (pinAt(n - 3) != pinAt(n - 4)) mChanged = 1'b1;
      else if (wrHit && bus.Address[3:2] == 2'd2 && bus.WriteData[0]) mChanged = 1'b0;
      if (wrHit && bus.Address[3:2] == 2'd0) mPortOut = bus.WriteData;
      if (wrHit && bus.Address[3:2] == 2'd3 && !busyAt(n - 1)) begin
        mActive = 1'b1;
        mStart  = n;
        mByte   = bus.WriteData[7:0];
      end
      mEdges = n;
    end
  end

  always @(negedge clk) begin
    logic [31:0] expRd;
    logic        expHit;
    expHit = (bus.Address[31:4] == BASE[31:4]);
    case (bus.Address[3:2])
      2'd0:    expRd = mPortOut;
      2'd1:    expRd = {24'h0, pinAt(mEdges - 2)};
      2'd2:    expRd = {30'h0, busyAt(mEdges), mChanged};
      default: expRd = 32'h0;
    endcase
    if (!(bus.MemRead && expHit)) expRd = 32'h0;
    chk("hit", {31'h0, bus.Hit}, {31'h0, expHit});
    chk("readData", bus.ReadData, expRd);
    chk("portOut", portOut, mPortOut);
    chk("txSerial", {31'h0, txSerial}, {31'h0, serialAt(mEdges)});
    chk("txBusy", {31'h0, txBusy}, {31'h0, busyAt(mEdges)});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    step();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rdChk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1;
    chk(name, bus.ReadData, exp);
    bus.MemRead = 1'b0;
  endtask

  // Sends one byte and samples the line mid-bit; optionally pokes TXDATA mid-frame
  // and on the edge the frame ends.
  task automatic runFrame(input logic [7:0] data, input bit pokes,
                          output logic [9:0] seq, output int busyCnt);
    busWrite(BASE + 32'hC, {24'h0, data});
    seq = 10'h0;
    busyCnt = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i % CPB == CPB / 2) seq[i / CPB] = txSerial;
      if (txBusy) busyCnt++;
      if (pokes && (i == 12 || i == 10 * CPB - 1)) begin
        bus.Address   = BASE + 32'hC;
        bus.WriteData = 32'h3C;
        bus.MemWrite  = 1'b1;
      end
      step();
      bus.MemWrite = 1'b0;
    end
  endtask

  initial begin
    logic [9:0] seq;
    int         busyCnt;
    int         idleBusy;

    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    chk("rstTxSerial", {31'h0, txSerial}, 32'h1);
    chk("rstTxBusy", {31'h0, txBusy}, 32'h0);
    chk("rstPortOut", portOut, 32'h0);
    for (int off = 0; off < 4; off++) rdChk("rstRead", BASE + 32'(off * 4), 32'h0);

    busWrite(BASE, 32'hDEADBEEF);
    chk("portOutWrite", portOut, 32'hDEADBEEF);
    rdChk("readOut", BASE + 32'h2, 32'hDEADBEEF);
    bus.Address = BASE + 32'h10;
    #1 chk("missHit", {31'h0, bus.Hit}, 32'h0);
    busWrite(BASE + 32'h10, 32'h12345678);
    chk("portOutMiss", portOut, 32'hDEADBEEF);

    portIn = 8'h5A;
    step();
    rdChk("inEdge1", BASE + 32'h4, 32'h0);
    step();
    rdChk("inEdge2", BASE + 32'h4, 32'h5A);
    rdChk("statusEdge2", BASE + 32'h8, 32'h0);
    step();
    rdChk("statusEdge3", BASE + 32'h8, 32'h1);
    busWrite(BASE + 32'h8, 32'h1);
    rdChk("statusClear", BASE + 32'h8, 32'h0);
    portIn = 8'hA5;
    step();
    step();
    busWrite(BASE + 32'h8, 32'h1);
    rdChk("statusSetWins", BASE + 32'h8, 32'h1);
    busWrite(BASE + 32'h8, 32'h1);
    rdChk("statusClear2", BASE + 32'h8, 32'h0);

    runFrame(8'hA5, 1'b0, seq, busyCnt);
    chk("frameA5", {22'h0, seq}, 32'h34A);
    chk("busyA5", busyCnt, 40);
    chk("idleAfterA5", {31'h0, txBusy}, 32'h0);

    runFrame(8'hA5, 1'b1, seq, busyCnt);
    chk("frameA5Poked", {22'h0, seq}, 32'h34A);
    chk("busyA5Poked", busyCnt, 40);
    idleBusy = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txBusy) idleBusy++;
      step();
    end
    chk("noSecondFrame", idleBusy, 0);

    busWrite(BASE + 32'hC, 32'hA5);
    repeat (14) step();
    reset = 1'b1;
    #1;
    chk("midResetSerial", {31'h0, txSerial}, 32'h1);
    chk("midResetBusy", {31'h0, txBusy}, 32'h0);
    chk("midResetPortOut", portOut, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("postResetIdle", {31'h0, txBusy}, 32'h0);
    runFrame(8'h0F, 1'b0, seq, busyCnt);
    chk("frame0F", {22'h0, seq}, 32'h21E);
    chk("busy0F", busyCnt, 40);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

`default_nettype wire
